// File: rtl/sequencer_pkg.sv
// Shared types and default sizes for the multichannel pattern sequencer.
package sequencer_pkg;

  localparam int DEFAULT_DATA_WIDTH         = 8;
  localparam int DEFAULT_ADDRESS_DEPTH      = 11;
  localparam int DEFAULT_NUMBER_OF_CHANNELS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } channel_state_t;

  function automatic int channel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sequencer_channel_ram.sv
// Per-channel pattern memory: simple dual-port, single clock, read-first.
module sequencer_channel_ram
  import sequencer_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_DEPTH = DEFAULT_ADDRESS_DEPTH
) (
  input  logic                     clock,
  input  logic                     write_enable,
  input  logic [ADDRESS_DEPTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic [ADDRESS_DEPTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0]    read_data
);

  logic [DATA_WIDTH-1:0] memory [2**ADDRESS_DEPTH];

  // Both updates are non-blocking, so a same-address read sees the old word.
  always_ff @(posedge clock) begin
    if (write_enable) memory[write_address] <= write_data;
    read_data <= memory[read_address];
  end

endmodule

// File: rtl/multichannel_sequencer.sv
// Multichannel pattern sequencer: each channel replays a RAM window as a loop.
// Optional build macro SEQUENCER_ONE_SHOT_EN adds play-once channels.
//
// state | meaning
// IDLE  | channel output forced to 0, read address held
// RUN   | read address steps through [start, end), reloading from shadow at wrap
module multichannel_sequencer
  import sequencer_pkg::*;
#(
  parameter  int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
  parameter  int ADDRESS_DEPTH      = DEFAULT_ADDRESS_DEPTH,
  parameter  int NUMBER_OF_CHANNELS = DEFAULT_NUMBER_OF_CHANNELS,
  localparam int CHANNEL_WIDTH      = channel_width(NUMBER_OF_CHANNELS)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 write_enable,
  input  logic [CHANNEL_WIDTH-1:0]             write_channel,
  input  logic [ADDRESS_DEPTH-1:0]             write_address,
  input  logic [DATA_WIDTH-1:0]                data_in,
  input  logic                                 config_write,
  input  logic [CHANNEL_WIDTH-1:0]             config_channel,
  input  logic [ADDRESS_DEPTH-1:0]             config_start_address,
  input  logic [ADDRESS_DEPTH-1:0]             config_end_address,
  input  logic                                 config_one_shot,
  input  logic [NUMBER_OF_CHANNELS-1:0]        trigger,
  input  logic [NUMBER_OF_CHANNELS-1:0]        halt,
  input  logic                                 sync_read_address,
  output logic [NUMBER_OF_CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic [NUMBER_OF_CHANNELS-1:0]        sync_out,
  output logic [NUMBER_OF_CHANNELS-1:0]        running
);

  logic [ADDRESS_DEPTH-1:0] shadow_start [NUMBER_OF_CHANNELS];
  logic [ADDRESS_DEPTH-1:0] shadow_end   [NUMBER_OF_CHANNELS];
`ifdef SEQUENCER_ONE_SHOT_EN
  logic shadow_one_shot [NUMBER_OF_CHANNELS];
`else
  logic unused_config_one_shot;
  assign unused_config_one_shot = config_one_shot;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUMBER_OF_CHANNELS; i++) begin
        shadow_start[i] <= '0;
        shadow_end[i]   <= '0;
`ifdef SEQUENCER_ONE_SHOT_EN
        shadow_one_shot[i] <= 1'b0;
`endif
      end
    end else if (config_write) begin
      for (int i = 0; i < NUMBER_OF_CHANNELS; i++) begin
        if (config_channel == CHANNEL_WIDTH'(i)) begin
          shadow_start[i] <= config_start_address;
          shadow_end[i]   <= config_end_address;
`ifdef SEQUENCER_ONE_SHOT_EN
          shadow_one_shot[i] <= config_one_shot;
`endif
        end
      end
    end
  end

  for (genvar ch = 0; ch < NUMBER_OF_CHANNELS; ch++) begin : g_channel
    channel_state_t           state_q, state_d;
    logic [ADDRESS_DEPTH-1:0] read_address_q, read_address_d;
    logic [ADDRESS_DEPTH-1:0] last_q, last_d;
    logic                     pass_start_q, pass_start_d;
    logic                     valid_q, sync_q, load;
    logic [DATA_WIDTH-1:0]    read_data;
`ifdef SEQUENCER_ONE_SHOT_EN
    logic                     one_shot_q, one_shot_d;
`endif

    sequencer_channel_ram #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDRESS_DEPTH(ADDRESS_DEPTH)
    ) u_ram (
      .clock        (clock),
      .write_enable (write_enable && (write_channel == CHANNEL_WIDTH'(ch))),
      .write_address(write_address),
      .write_data   (data_in),
      .read_address (read_address_q),
      .read_data    (read_data)
    );

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state_q        <= IDLE;
        read_address_q <= '0;
        last_q         <= '0;
        pass_start_q   <= 1'b0;
        valid_q        <= 1'b0;
        sync_q         <= 1'b0;
`ifdef SEQUENCER_ONE_SHOT_EN
        one_shot_q     <= 1'b0;
`endif
      end else begin
        state_q        <= state_d;
        read_address_q <= read_address_d;
        last_q         <= last_d;
        pass_start_q   <= pass_start_d;
        // Flags ride alongside the one-cycle RAM read.
        valid_q        <= (state_q == RUN);
        sync_q         <= (state_q == RUN) && pass_start_q;
`ifdef SEQUENCER_ONE_SHOT_EN
        one_shot_q     <= one_shot_d;
`endif
      end
    end

    always_comb begin
      state_d        = state_q;
      read_address_d = read_address_q;
      last_d         = last_q;
      pass_start_d   = 1'b0;
      load           = 1'b0;
`ifdef SEQUENCER_ONE_SHOT_EN
      one_shot_d     = one_shot_q;
`endif
      if (halt[ch]) begin
        state_d = IDLE;
      end else if (trigger[ch] || (sync_read_address && state_q == RUN)) begin
        load = 1'b1;
      end else if (state_q == RUN) begin
        if (read_address_q == last_q) begin
`ifdef SEQUENCER_ONE_SHOT_EN
          if (one_shot_q) state_d = IDLE;
          else            load    = 1'b1;
`else
          load = 1'b1;
`endif
        end else begin
          read_address_d = read_address_q + 1'b1;
        end
      end
      // Every new pass picks up the shadow settings, never mid-pass.
      if (load) begin
        state_d        = RUN;
        read_address_d = shadow_start[ch];
        last_d         = shadow_end[ch] - 1'b1;
        pass_start_d   = 1'b1;
`ifdef SEQUENCER_ONE_SHOT_EN
        one_shot_d     = shadow_one_shot[ch];
`endif
      end
    end

    assign data_out[ch*DATA_WIDTH +: DATA_WIDTH] = valid_q ? read_data : '0;
    assign sync_out[ch] = sync_q;
    assign running[ch]  = (state_q == RUN);
  end

endmodule

// File: tb/tb_multichannel_sequencer.sv
// Scoreboard bench for multichannel_sequencer: a pass-level model predicts every cycle's outputs.
module tb_multichannel_sequencer;

  localparam int DW = 8, AD = 11, NC = 4, CW = 2, D = 2048;
`ifdef SEQUENCER_ONE_SHOT_EN
  localparam bit ONE_SHOT_EN = 1'b1;
`else
  localparam bit ONE_SHOT_EN = 1'b0;
`endif

  logic clock, reset, write_enable, config_write, config_one_shot, sync_read_address;
  logic [CW-1:0] write_channel, config_channel;
  logic [AD-1:0] write_address, config_start_address, config_end_address;
  logic [DW-1:0] data_in;
  logic [NC-1:0] trigger, halt, sync_out, running;
  logic [NC*DW-1:0] data_out;

  multichannel_sequencer dut (
    .clock(clock), .reset(reset),
    .write_enable(write_enable), .write_channel(write_channel),
    .write_address(write_address), .data_in(data_in),
    .config_write(config_write), .config_channel(config_channel),
    .config_start_address(config_start_address), .config_end_address(config_end_address),
    .config_one_shot(config_one_shot), .trigger(trigger), .halt(halt),
    .sync_read_address(sync_read_address),
    .data_out(data_out), .sync_out(sync_out), .running(running)
  );

  typedef struct {
    logic [NC*DW-1:0] data;
    logic [NC-1:0]    sync;
    logic [NC-1:0]    run;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int errors = 0, checks = 0, cycle_n = 0;

  // Reference model: each pass is a base address, a length and a position.
  logic [DW-1:0] mem_m [NC][D];
  int sh_start[NC], sh_end[NC];
  bit sh_os[NC];
  bit playing[NC], os[NC];
  int base[NC], len[NC], pos[NC];
  int ramp_exp[9] = '{4, 5, 6, 7, 4, 5, 6, 7, 4};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    cycle_n++;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (data_out !== mon_e.data) begin
        errors++;
        $display("FAIL data_out cycle %0d actual=%h expected=%h", cycle_n, data_out, mon_e.data);
      end
      checks++;
      if (sync_out !== mon_e.sync) begin
        errors++;
        $display("FAIL sync_out cycle %0d actual=%b expected=%b", cycle_n, sync_out, mon_e.sync);
      end
      checks++;
      if (running !== mon_e.run) begin
        errors++;
        $display("FAIL running cycle %0d actual=%b expected=%b", cycle_n, running, mon_e.run);
      end
    end
  end

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic begin_pass(int ch);
    playing[ch] = 1'b1;
    base[ch]    = sh_start[ch];
    len[ch]     = (sh_end[ch] - sh_start[ch] + D) % D;
    if (len[ch] == 0) len[ch] = D;
    pos[ch]     = 0;
    os[ch]      = ONE_SHOT_EN && sh_os[ch];
  endtask

  // Predicts the next cycle's outputs from this cycle's inputs, then clocks.
  task automatic step();
    exp_t e;
    e.data = '0; e.sync = '0; e.run = '0;
    if (!reset) begin
      for (int ch = 0; ch < NC; ch++) begin
        playing[ch] = 1'b0; sh_start[ch] = 0; sh_end[ch] = 0; sh_os[ch] = 1'b0;
      end
    end else begin
      for (int ch = 0; ch < NC; ch++) begin
        if (playing[ch]) begin
          e.data[ch*DW +: DW] = mem_m[ch][(base[ch] + pos[ch]) % D];
          e.sync[ch] = (pos[ch] == 0);
        end
        if (halt[ch]) playing[ch] = 1'b0;
        else if (trigger[ch] || (sync_read_address && playing[ch])) begin_pass(ch);
        else if (playing[ch]) begin
          pos[ch]++;
          if (pos[ch] == len[ch]) begin
            if (os[ch]) playing[ch] = 1'b0;
            else        begin_pass(ch);
          end
        end
        e.run[ch] = playing[ch];
      end
      if (write_enable) mem_m[write_channel][write_address] = data_in;
      if (config_write) begin
        sh_start[config_channel] = int'(config_start_address);
        sh_end[config_channel]   = int'(config_end_address);
        sh_os[config_channel]    = config_one_shot;
      end
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    trigger = '0; halt = '0; sync_read_address = 1'b0;
    write_enable = 1'b0; config_write = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic cfg(int ch, int s, int e, bit o);
    config_write = 1'b1; config_channel = CW'(ch);
    config_start_address = AD'(s); config_end_address = AD'(e); config_one_shot = o;
    step();
  endtask

  task automatic trig(logic [NC-1:0] m);
    trigger = m;
    step();
  endtask

  initial begin
    exp_t z;
    int s, ch;
    reset = 1'b0; write_enable = 1'b0; write_channel = '0; write_address = '0; data_in = '0;
    config_write = 1'b0; config_channel = '0; config_start_address = '0;
    config_end_address = '0; config_one_shot = 1'b0;
    trigger = '0; halt = '0; sync_read_address = 1'b0;
    for (int c = 0; c < NC; c++) begin
      playing[c] = 1'b0; sh_start[c] = 0; sh_end[c] = 0; sh_os[c] = 1'b0;
      base[c] = 0; len[c] = D; pos[c] = 0; os[c] = 1'b0;
    end

    idle(3);
    chk("reset_data_out", int'(data_out), 0);
    chk("reset_running", int'(running), 0);
    chk("reset_sync_out", int'(sync_out), 0);
    reset = 1'b1;

    for (int c = 0; c < NC; c++)
      for (int a = 0; a < D; a++) begin
        write_enable = 1'b1; write_channel = CW'(c); write_address = AD'(a);
        data_in = (c == 0) ? DW'(a) : DW'($urandom);
        step();
      end

    // Ramp loop 4..7 on channel 0
    cfg(0, 4, 8, 0);
    trig(4'b0001);
    chk("ramp_latency", int'(data_out[7:0]), 0);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("ramp_word", int'(data_out[7:0]), ramp_exp[i]);
      chk("ramp_sync", int'(sync_out[0]), int'(ramp_exp[i] == 4));
    end

    // Shadow end change mid-pass: 5,6,7 then a 4..19 pass
    cfg(0, 4, 20, 0);
    idle(3);
    chk("shadow_pass_restart", int'(data_out[7:0]), 4);
    idle(4);
    chk("shadow_new_end", int'(data_out[7:0]), 8);
    idle(20);
    halt = 4'b0001; step();

    cfg(1, 10, 13, 1);
    trig(4'b0010);
    idle(10);
    halt = 4'b0010; step();

    cfg(3, 2046, 2, 0);
    trig(4'b1000);
    idle(12);
    halt = 4'b1000; step();

    // Priority: halt beats trigger; sync restarts only running channels
    cfg(0, 100, 200, 0);
    cfg(1, 500, 600, 0);
    cfg(2, 300, 400, 0);
    trig(4'b0111);
    idle(5);
    halt = 4'b0010; trigger = 4'b0010; step();
    chk("prio_halt_ch1", int'(running[1]), 0);
    chk("prio_run_ch0", int'(running[0]), 1);
    idle(3);
    sync_read_address = 1'b1; step();
    step();
    chk("sync_out_mask", int'(sync_out), 5);
    chk("sync_restart_word", int'(data_out[7:0]), 100);
    idle(3);
    halt = 4'b1111; step();

    // Full depth: start == end gives a 2048-cycle period
    cfg(2, 0, 0, 0);
    trig(4'b0100);
    step();
    chk("full_depth_sync0", int'(sync_out[2]), 1);
    idle(2047);
    chk("full_depth_nosync", int'(sync_out[2]), 0);
    step();
    chk("full_depth_sync1", int'(sync_out[2]), 1);
    halt = 4'b0100; step();

    for (int c = 0; c < NC; c++) begin
      s = int'($urandom % D);
      cfg(c, s, (s + int'($urandom_range(1, 24))) % D, 1'($urandom % 2));
    end
    trig(4'b1111);
    for (int n = 0; n < 500; n++) begin
      for (int c = 0; c < NC; c++) begin
        trigger[c] = ($urandom % 16 == 0);
        halt[c]    = ($urandom % 40 == 0);
      end
      sync_read_address = ($urandom % 50 == 0);
      if ($urandom % 8 == 0) begin
        s = int'($urandom % D);
        config_write = 1'b1; config_channel = CW'($urandom % NC);
        config_start_address = AD'(s);
        config_end_address = ($urandom % 6 == 0) ? AD'(s) : AD'(s + int'($urandom_range(1, 24)));
        config_one_shot = 1'($urandom % 2);
      end
      if ($urandom % 2 == 0) begin
        ch = 1 + int'($urandom % 3);
        write_enable = 1'b1; write_channel = CW'(ch); data_in = DW'($urandom);
        write_address = playing[ch] ? AD'((base[ch] + pos[ch]) % D) : AD'($urandom);
      end
      step();
    end
    halt = 4'b1111; step();

    // Asynchronous reset while channel 0 shows word 6
    cfg(0, 4, 8, 0);
    trig(4'b0001);
    idle(3);
    chk("pre_reset_word", int'(data_out[7:0]), 6);
    reset = 1'b0;
    #1;
    chk("async_reset_data", int'(data_out), 0);
    chk("async_reset_sync", int'(sync_out), 0);
    chk("async_reset_running", int'(running), 0);
    exp_q.delete();
    z.data = '0; z.sync = '0; z.run = '0;
    exp_q.push_back(z);
    idle(2);
    reset = 1'b1;
    idle(6);
    chk("post_reset_quiet", int'(data_out), 0);
    trig(4'b0001);
    idle(6);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multichannel_sequencer.md
MULTICHANNEL_SEQUENCER -- requirements
Module: multichannel_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each sample word, matching the downstream oserdes input width.
REQ-002 Parameter ADDRESS_DEPTH, default 11: log2 of the per-channel pattern memory depth, in words.
REQ-003 Parameter NUMBER_OF_CHANNELS, default 4: number of independent pattern channels; CHANNEL_WIDTH = max(1, clog2(NUMBER_OF_CHANNELS)).
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 Port clock, input, 1: sole clock for every register and the memory.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port write_enable, input, 1: write data_in to the pattern memory of write_channel at write_address.
REQ-008 Port write_channel, input, CHANNEL_WIDTH: target channel of the memory write.
REQ-009 Port write_address, input, ADDRESS_DEPTH: target word of the memory write.
REQ-010 Port data_in, input, DATA_WIDTH: memory write data.
REQ-011 Port config_write, input, 1: load the config_* values into the shadow registers of config_channel.
REQ-012 Port config_channel, input, CHANNEL_WIDTH: target channel of the configuration write.
REQ-013 Port config_start_address, input, ADDRESS_DEPTH: first word of the pattern.
REQ-014 Port config_end_address, input, ADDRESS_DEPTH: one past the last word of the pattern, modulo 2^ADDRESS_DEPTH.
REQ-015 Port config_one_shot, input, 1: 1 = play once and stop; 0 = loop.
REQ-016 Port trigger, input, NUMBER_OF_CHANNELS: per-channel start pulse.
REQ-017 Port halt, input, NUMBER_OF_CHANNELS: per-channel stop pulse.
REQ-018 Port sync_read_address, input, 1: restart every running channel at its start address.
REQ-019 Port data_out, output, NUMBER_OF_CHANNELS*DATA_WIDTH: channel n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-020 Port sync_out, output, NUMBER_OF_CHANNELS: one-cycle pulse, coincident with the start word on data_out.
REQ-021 Port running, output, NUMBER_OF_CHANNELS: channel n is in state RUN.

Function
REQ-022 Each channel shall have the states IDLE and RUN; in IDLE, data_out for that channel shall be 0 and read_address shall hold.
REQ-023 A trigger in IDLE shall move the channel to RUN and copy the shadow start, last (= end - 1, mod 2^ADDRESS_DEPTH) and one_shot into the active registers.
REQ-024 In RUN, read_address shall increment by 1 each cycle, modulo 2^ADDRESS_DEPTH; when read_address equals last, the channel shall reload start, last and one_shot from shadow (loop) or return to IDLE (one_shot).
REQ-025 Memory read latency shall be one cycle: the word at the address presented in cycle N appears on data_out in cycle N+1.
REQ-026 sync_out shall pulse in the cycle that data_out shows the start word of each pass.
REQ-027 Trigger to first word on data_out shall be exactly 2 cycles.
REQ-028 start == end shall give a full 2^ADDRESS_DEPTH-word pattern.
REQ-029 end < start shall wrap through address 2^ADDRESS_DEPTH-1 to 0.
REQ-030 sync_read_address or trigger while in RUN shall restart at shadow start immediately; these shall take priority over wrap.
REQ-031 halt shall force IDLE on the next edge and shall take priority over trigger and sync_read_address.
REQ-032 A config_write shall never alter an active pass; it shall take effect only at the next wrap or trigger.
REQ-033 A write and a read to the same channel and address in the same cycle shall return the old data (read-first).

Reset
REQ-034 While reset is low: all channels IDLE; data_out, sync_out and running all 0; read addresses 0.
REQ-035 Shadow start = 0, shadow end = 0 (full depth), shadow one_shot = 0.
REQ-036 Memory contents are not reset.
REQ-037 Reset asserted mid-pattern shall take effect asynchronously, with no further sync_out.

Configuration
REQ-038 With SEQUENCER_ONE_SHOT_EN defined, config_one_shot shall behave as in REQ-024.
REQ-039 Without SEQUENCER_ONE_SHOT_EN, config_one_shot shall be ignored, channels shall always loop, and no one_shot registers shall exist.

Structure
REQ-040 Package sequencer_pkg shall hold the channel state enum (IDLE, RUN) and the default parameter constants.
REQ-041 One sub-module, sequencer_channel_ram: a simple dual-port, read-first, single-clock inferred RAM, instantiated once per channel by a generate loop.

Verification
REQ-042 Ramp test: write mem[ch0][a] = a[7:0]; start = 4, end = 8, loop; trigger ch0 -> data_out ch0 = 0 for 2 cycles, then 4,5,6,7,4,5,...; sync_out pulses with each 4.
REQ-043 One-shot test: start = 10, end = 13, one_shot = 1 -> data 10,11,12 once; running falls after 12; data_out returns to 0.
REQ-044 Wrap and full-depth test: start = 2046, end = 2 -> 2046,2047,0,1 repeating; start = end = 0 -> period 2048 cycles.
REQ-045 Shadow test: config end = 20 during a pass with end = 8 -> current pass still ends at 7; next pass runs 4..19.
REQ-046 Priority test: halt and trigger on ch1 in the same cycle -> ch1 goes IDLE; sync_read_address mid-pass restarts ch0 and ch2 only, with sync_out 2 cycles later.
REQ-047 Reset test: reset low at pattern word 6 -> all outputs 0 immediately; after reset release, no output until a trigger.
